ppu_timing_gen: RTL and testbench

- Synthesizes PPU-style video timing strobes (vblank, hblank, csync_n, burst_n) from a free-running dot/line raster counter.
- Used as a bench/bring-up stimulus source in place of the real PPU. Drives the same four signals the interrupt-capture logic consumes.
- Single clock domain. One enabled clock equals one dot.

---
 rtl/ppu_timing_gen.sv | 102 ++++++++++
 tb/tb_ppu_timing_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_timing_gen.sv
// Free-running dot/line raster that produces PPU-style hblank/vblank/csync_n/burst_n strobes for bring-up.
// Latency: all outputs are registered; strobes decode the same h_o/v_o they are presented with (1-cycle update from enable_i).
// Backpressure: none; enable_i low freezes the raster and strobes, and clears frame_start_o.
module ppu_timing_gen #(
    parameter int H_TOTAL      = 341,
    parameter int V_TOTAL      = 262,
    parameter int HBLANK_START = 274,
    parameter int HSYNC_START  = 290,
    parameter int HSYNC_WIDTH  = 25,
    parameter int BURST_START  = 320,
    parameter int BURST_WIDTH  = 15,
    parameter int VBLANK_START = 225,
    parameter int VSYNC_START  = 240,
    parameter int VSYNC_LINES  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    output logic [8:0] h_o,
    output logic [8:0] v_o,
    output logic       frame_start_o,
    output logic       hblank,
    output logic       vblank,
    output logic       csync_n,
    output logic       burst_n
);

    localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
    localparam logic [8:0] HB_START  = 9'(HBLANK_START);
    localparam logic [8:0] HS_START  = 9'(HSYNC_START);
    localparam logic [8:0] HS_END    = 9'(HSYNC_START + HSYNC_WIDTH);
    localparam logic [8:0] BU_START  = 9'(BURST_START);
    localparam logic [8:0] BU_END    = 9'(BURST_START + BURST_WIDTH);
    localparam logic [8:0] VB_START  = 9'(VBLANK_START);
    localparam logic [8:0] VS_START  = 9'(VSYNC_START);
    localparam logic [8:0] VS_END    = 9'(VSYNC_START + VSYNC_LINES);

    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic       wrap_nxt;

    always_comb begin
        h_nxt    = h_o;
        v_nxt    = v_o;
        wrap_nxt = 1'b0;
        if (enable_i) begin
            if (h_o == H_LAST) begin
                h_nxt = '0;
                if (v_o == V_LAST) begin
                    v_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    v_nxt = v_o + 9'd1;
                end
            end else begin
                h_nxt = h_o + 9'd1;
            end
        end
    end

    // Decode the next-state position so the registered strobes line up with h_o/v_o.
    logic hblank_nxt;
    logic vblank_nxt;
    logic hsync_win;
    logic vsync_line;
    logic burst_win;
    logic csync_n_nxt;
    logic burst_n_nxt;

    always_comb begin
        hblank_nxt  = (h_nxt >= HB_START);
        vblank_nxt  = (v_nxt >= VB_START);
        hsync_win   = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vsync_line  = (v_nxt >= VS_START) && (v_nxt < VS_END);
        burst_win   = (h_nxt >= BU_START) && (h_nxt < BU_END);
        // Vsync lines use inverted serration: sync is high only inside the hsync window.
        csync_n_nxt = vsync_line ? hsync_win : ~hsync_win;
        burst_n_nxt = ~(burst_win && !vblank_nxt);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            h_o           <= '0;
            v_o           <= '0;
            frame_start_o <= 1'b0;
            hblank        <= 1'b0;
            vblank        <= 1'b0;
            csync_n       <= 1'b1;
            burst_n       <= 1'b1;
        end else begin
            h_o           <= h_nxt;
            v_o           <= v_nxt;
            frame_start_o <= wrap_nxt;
            hblank        <= hblank_nxt;
            vblank        <= vblank_nxt;
            csync_n       <= csync_n_nxt;
            burst_n       <= burst_n_nxt;
        end
    end

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Bench for ppu_timing_gen: a full-size raster for line timing and a shrunken raster for frame-level behaviour.
module tb_ppu_timing_gen;

    localparam int D_HT = 341, D_VT = 262, D_HBS = 274, D_HSS = 290, D_HSW = 25;
    localparam int D_BS = 320, D_BW = 15, D_VBS = 225, D_VSS = 240, D_VSL = 3;
    localparam int S_HT = 40, S_VT = 20, S_HBS = 24, S_HSS = 27, S_HSW = 5;
    localparam int S_BS = 34, S_BW = 4, S_VBS = 12, S_VSS = 14, S_VSL = 3;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       fs;
        logic       hb;
        logic       vb;
        logic       cs;
        logic       bn;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable_i = 1'b0;

    logic [8:0] h_d, v_d, h_s, v_s;
    logic fs_d, hb_d, vb_d, cs_d, bn_d;
    logic fs_s, hb_s, vb_s, cs_s, bn_s;

    int tests = 0;
    int fails = 0;
    int pos_d = 0, pos_s = 0;
    exp_t q_d[$];
    exp_t q_s[$];

    always #5 clock = ~clock;

    ppu_timing_gen dut (
        .clock(clock), .reset(reset), .enable_i(enable_i),
        .h_o(h_d), .v_o(v_d), .frame_start_o(fs_d),
        .hblank(hb_d), .vblank(vb_d), .csync_n(cs_d), .burst_n(bn_d)
    );

    ppu_timing_gen #(
        .H_TOTAL(S_HT), .V_TOTAL(S_VT), .HBLANK_START(S_HBS), .HSYNC_START(S_HSS),
        .HSYNC_WIDTH(S_HSW), .BURST_START(S_BS), .BURST_WIDTH(S_BW),
        .VBLANK_START(S_VBS), .VSYNC_START(S_VSS), .VSYNC_LINES(S_VSL)
    ) dut_s (
        .clock(clock), .reset(reset), .enable_i(enable_i),
        .h_o(h_s), .v_o(v_s), .frame_start_o(fs_s),
        .hblank(hb_s), .vblank(vb_s), .csync_n(cs_s), .burst_n(bn_s)
    );

    // Reference: position is a linear dot index within the frame.
    function automatic exp_t dec(input int pos, input logic fs, input int ht, input int hbs,
                                 input int hss, input int hsw, input int bs, input int bw,
                                 input int vbs, input int vss, input int vsl);
        exp_t e;
        int h;
        int v;
        logic hs;
        logic vs;
        h    = pos % ht;
        v    = pos / ht;
        hs   = (h >= hss) && (h < hss + hsw);
        vs   = (v >= vss) && (v < vss + vsl);
        e.h  = 9'(h);
        e.v  = 9'(v);
        e.fs = fs;
        e.hb = (h >= hbs);
        e.vb = (v >= vbs);
        e.cs = (hs == vs);
        e.bn = !((h >= bs) && (h < bs + bw) && !(v >= vbs));
        return e;
    endfunction

    task automatic step(input logic en, input logic rst);
        exp_t ed;
        exp_t es;
        exp_t ad;
        exp_t as_s;
        logic fsd;
        logic fss;
        @(negedge clock);
        enable_i = en;
        reset    = rst;
        fsd = 1'b0;
        fss = 1'b0;
        if (!rst) begin
            pos_d = 0;
            pos_s = 0;
        end else if (en) begin
            pos_d = (pos_d + 1) % (D_HT * D_VT);
            pos_s = (pos_s + 1) % (S_HT * S_VT);
            fsd   = (pos_d == 0);
            fss   = (pos_s == 0);
        end
        q_d.push_back(dec(pos_d, fsd, D_HT, D_HBS, D_HSS, D_HSW, D_BS, D_BW, D_VBS, D_VSS, D_VSL));
        q_s.push_back(dec(pos_s, fss, S_HT, S_HBS, S_HSS, S_HSW, S_BS, S_BW, S_VBS, S_VSS, S_VSL));
        @(posedge clock);
        #1;
        ed   = q_d.pop_front();
        es   = q_s.pop_front();
        ad   = '{h: h_d, v: v_d, fs: fs_d, hb: hb_d, vb: vb_d, cs: cs_d, bn: bn_d};
        as_s = '{h: h_s, v: v_s, fs: fs_s, hb: hb_s, vb: vb_s, cs: cs_s, bn: bn_s};
        tests++;
        if (ad !== ed) begin
            fails++;
            $display("FAIL sb_full t=%0t actual h=%0d v=%0d fs/hb/vb/cs/bn=%b%b%b%b%b required h=%0d v=%0d fs/hb/vb/cs/bn=%b%b%b%b%b",
                     $time, ad.h, ad.v, ad.fs, ad.hb, ad.vb, ad.cs, ad.bn, ed.h, ed.v, ed.fs, ed.hb, ed.vb, ed.cs, ed.bn);
        end
        tests++;
        if (as_s !== es) begin
            fails++;
            $display("FAIL sb_small t=%0t actual h=%0d v=%0d fs/hb/vb/cs/bn=%b%b%b%b%b required h=%0d v=%0d fs/hb/vb/cs/bn=%b%b%b%b%b",
                     $time, as_s.h, as_s.v, as_s.fs, as_s.hb, as_s.vb, as_s.cs, as_s.bn, es.h, es.v, es.fs, es.hb, es.vb, es.cs, es.bn);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        tests++; if (h_d !== 9'd0)   begin fails++; $display("FAIL reset_h actual=%0d required=0", h_d); end
        tests++; if (v_d !== 9'd0)   begin fails++; $display("FAIL reset_v actual=%0d required=0", v_d); end
        tests++; if (hb_d !== 1'b0)  begin fails++; $display("FAIL reset_hblank actual=%b required=0", hb_d); end
        tests++; if (vb_d !== 1'b0)  begin fails++; $display("FAIL reset_vblank actual=%b required=0", vb_d); end
        tests++; if (cs_d !== 1'b1)  begin fails++; $display("FAIL reset_csync_n actual=%b required=1", cs_d); end
        tests++; if (bn_d !== 1'b1)  begin fails++; $display("FAIL reset_burst_n actual=%b required=1", bn_d); end
        tests++; if (fs_d !== 1'b0)  begin fails++; $display("FAIL reset_frame_start actual=%b required=0", fs_d); end
    endtask

    task automatic test_one_line();
        int hb_rise, hb_fall, cs_first, cs_len, bn_first, bn_len;
        logic prev_hb;
        step(1'b1, 1'b0);
        hb_rise = -1; hb_fall = -1; cs_first = -1; cs_len = 0; bn_first = -1; bn_len = 0;
        prev_hb = hb_d;
        for (int n = 1; n <= D_HT; n++) begin
            step(1'b1, 1'b1);
            if (hb_d && !prev_hb && hb_rise < 0) hb_rise = n;
            if (!hb_d && prev_hb && hb_fall < 0) hb_fall = n;
            prev_hb = hb_d;
            if (!cs_d) begin cs_len++; if (cs_first < 0) cs_first = int'(h_d); end
            if (!bn_d) begin bn_len++; if (bn_first < 0) bn_first = int'(h_d); end
        end
        tests++; if (hb_rise != 274) begin fails++; $display("FAIL line_hblank_rise actual=%0d required=274", hb_rise); end
        tests++; if (hb_fall != 341) begin fails++; $display("FAIL line_hblank_fall actual=%0d required=341", hb_fall); end
        tests++; if (cs_first != 290) begin fails++; $display("FAIL line_csync_start actual=%0d required=290", cs_first); end
        tests++; if (cs_len != 25)   begin fails++; $display("FAIL line_csync_len actual=%0d required=25", cs_len); end
        tests++; if (bn_first != 320) begin fails++; $display("FAIL line_burst_start actual=%0d required=320", bn_first); end
        tests++; if (bn_len != 15)   begin fails++; $display("FAIL line_burst_len actual=%0d required=15", bn_len); end
        tests++; if (h_d !== 9'd0)   begin fails++; $display("FAIL line_end_h actual=%0d required=0", h_d); end
        tests++; if (v_d !== 9'd1)   begin fails++; $display("FAIL line_end_v actual=%0d required=1", v_d); end
    endtask

    task automatic test_enable_gating();
        int cs_cnt, hb_cnt, bn_cnt, hold_err;
        logic [8:0] prev_h;
        logic en;
        step(1'b1, 1'b0);
        cs_cnt = 0; hb_cnt = 0; bn_cnt = 0; hold_err = 0;
        for (int i = 0; i < 3 * D_HT; i++) begin
            en = ((i % 3) == 0);
            prev_h = h_d;
            step(en, 1'b1);
            if (en) begin
                if (!cs_d) cs_cnt++;
                if (hb_d)  hb_cnt++;
                if (!bn_d) bn_cnt++;
            end else if (h_d !== prev_h || fs_d !== 1'b0) begin
                hold_err++;
            end
        end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL gate_hold actual=%0d errors required=0", hold_err); end
        tests++; if (cs_cnt != 25)  begin fails++; $display("FAIL gate_csync_len actual=%0d required=25", cs_cnt); end
        tests++; if (hb_cnt != 67)  begin fails++; $display("FAIL gate_hblank_len actual=%0d required=67", hb_cnt); end
        tests++; if (bn_cnt != 15)  begin fails++; $display("FAIL gate_burst_len actual=%0d required=15", bn_cnt); end
        tests++; if (h_d !== 9'd0 || v_d !== 9'd1) begin
            fails++; $display("FAIL gate_end_pos actual=(%0d,%0d) required=(0,1)", h_d, v_d);
        end
    endtask

    task automatic test_frame_wrap();
        int pulses, first_n, second_n, bad_pos, vb_cnt, burst_vb;
        step(1'b1, 1'b0);
        pulses = 0; first_n = -1; second_n = -1; bad_pos = 0; vb_cnt = 0; burst_vb = 0;
        for (int n = 1; n <= 2 * S_HT * S_VT; n++) begin
            step(1'b1, 1'b1);
            if (fs_s) begin
                pulses++;
                if (first_n < 0) first_n = n; else if (second_n < 0) second_n = n;
                if (h_s !== 9'd0 || v_s !== 9'd0) bad_pos++;
            end
            if (n <= S_HT * S_VT && vb_s) vb_cnt++;
            if (vb_s && !bn_s) burst_vb++;
        end
        tests++; if (pulses != 2)    begin fails++; $display("FAIL wrap_pulses actual=%0d required=2", pulses); end
        tests++; if (first_n != 800) begin fails++; $display("FAIL wrap_first actual=%0d required=800", first_n); end
        tests++; if (second_n != 1600) begin fails++; $display("FAIL wrap_period actual=%0d required=1600", second_n); end
        tests++; if (bad_pos != 0)   begin fails++; $display("FAIL wrap_pos actual=%0d bad required=0", bad_pos); end
        tests++; if (vb_cnt != 320)  begin fails++; $display("FAIL wrap_vblank_len actual=%0d required=320", vb_cnt); end
        tests++; if (burst_vb != 0)  begin fails++; $display("FAIL wrap_burst_in_vblank actual=%0d required=0", burst_vb); end
    endtask

    task automatic test_vsync();
        int vs_hi, vs_bad, l17_lo;
        logic in_win;
        vs_hi = 0; vs_bad = 0; l17_lo = 0;
        for (int n = 0; n < S_HT * S_VT; n++) begin
            step(1'b1, 1'b1);
            in_win = (int'(h_s) >= S_HSS) && (int'(h_s) < S_HSS + S_HSW);
            if (int'(v_s) >= S_VSS && int'(v_s) < S_VSS + S_VSL) begin
                if (cs_s) vs_hi++;
                if (cs_s !== in_win) vs_bad++;
            end
            if (int'(v_s) == S_VSS + S_VSL && !cs_s) l17_lo++;
        end
        tests++; if (vs_hi != 15)  begin fails++; $display("FAIL vsync_high_cnt actual=%0d required=15", vs_hi); end
        tests++; if (vs_bad != 0)  begin fails++; $display("FAIL vsync_polarity actual=%0d bad required=0", vs_bad); end
        tests++; if (l17_lo != 5)  begin fails++; $display("FAIL vsync_after_line actual=%0d required=5", l17_lo); end
    endtask

    task automatic test_mid_reset();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 900 && !found; n++) begin
            step(1'b1, 1'b1);
            if (h_s == 9'(S_HSS + 1) && v_s == 9'(S_VSS + 1)) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL midrst_reach actual=not_reached required=(28,15)"); end
        step(1'b1, 1'b0);
        tests++; if (h_s !== 9'd0 || v_s !== 9'd0) begin
            fails++; $display("FAIL midrst_pos actual=(%0d,%0d) required=(0,0)", h_s, v_s);
        end
        tests++; if (cs_s !== 1'b1) begin fails++; $display("FAIL midrst_csync actual=%b required=1", cs_s); end
        tests++; if (vb_s !== 1'b0) begin fails++; $display("FAIL midrst_vblank actual=%b required=0", vb_s); end
        tests++; if (fs_s !== 1'b0) begin fails++; $display("FAIL midrst_frame_start actual=%b required=0", fs_s); end
        step(1'b1, 1'b1);
        tests++; if (h_s !== 9'd1 || fs_s !== 1'b0) begin
            fails++; $display("FAIL midrst_resume actual=h%0d fs%b required=h1 fs0", h_s, fs_s);
        end
    endtask

    initial begin
        test_reset();
        test_one_line();
        test_enable_gating();
        test_frame_wrap();
        test_vsync();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
